// File: rtl/fa_ctrl_seq_if.sv
// Sequencer-to-datapath/memory bundle: fetch handshake, carry feedback and all datapath strobes.
// The sequencer side uses master; the memory/datapath side uses slave.
interface fa_ctrl_seq_if #(
  parameter int INSTR_W    = 8,
  parameter int REG_ADDR_W = 4
);
  logic [INSTR_W-1:0]    instr_in;
  logic                  mem_ack;
  logic                  carry_in;
  logic                  mem_req;
  logic                  ir_load;
  logic                  op2_load;
  logic                  pc_inc;
  logic                  pc_load;
  logic [1:0]            alu_op;
  logic                  acc_we;
  logic [1:0]            acc_src;
  logic                  tmp_we;
  logic                  reg_we;
  logic                  reg_src;
  logic [REG_ADDR_W-1:0] reg_addr;
  logic                  carry_we;
  logic                  halted;
  logic                  illegal;

  modport master (
    input  instr_in, mem_ack, carry_in,
    output mem_req, ir_load, op2_load, pc_inc, pc_load, alu_op, acc_we, acc_src,
           tmp_we, reg_we, reg_src, reg_addr, carry_we, halted, illegal
  );

  modport slave (
    output instr_in, mem_ack, carry_in,
    input  mem_req, ir_load, op2_load, pc_inc, pc_load, alu_op, acc_we, acc_src,
           tmp_we, reg_we, reg_src, reg_addr, carry_we, halted, illegal
  );
endinterface

// File: rtl/fa_ctrl_seq.sv
// FA4 control sequencer: fetch (req/ack, waits stall FETCH/FETCH2), decode, then 1-3 strobe cycles.
// Strobes decode combinationally from state, IR, mem_ack and carry_in; reset forces every output low.
module fa_ctrl_seq #(
  parameter int INSTR_W    = 8,
  parameter int OPC_W      = 4,
  parameter int REG_ADDR_W = 4
) (
  input  logic          clock,
  input  logic          reset,
  fa_ctrl_seq_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_XCH1, S_XCH2, S_XCH3, S_FETCH2, S_JUMP, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_XCH = 4'h3;
  localparam logic [3:0] OP_LDM = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_INC = 4'h6;
  localparam logic [3:0] OP_JCN = 4'h7;
  localparam logic [3:0] OP_JUN = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q;
  logic [OPC_W-1:0]     opc;
  logic [3:0]           opc_lo;
  logic                 opc_hi_ok;

  logic                  mem_req, ir_load, op2_load, pc_inc, pc_load;
  logic [1:0]            alu_op, acc_src;
  logic                  acc_we, tmp_we, reg_we, reg_src, carry_we, halted, illegal;
  logic [REG_ADDR_W-1:0] reg_addr;

  assign opc       = ir_q[INSTR_W-1 -: OPC_W];
  assign opc_lo    = opc[3:0];
  // Wide opcode fields reserve their upper bits; anything non-zero there is undefined.
  assign opc_hi_ok = (opc >> 4) == '0;

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    ir_load  = 1'b0;
    op2_load = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    alu_op   = 2'b00;
    acc_we   = 1'b0;
    acc_src  = 2'b00;
    tmp_we   = 1'b0;
    reg_we   = 1'b0;
    reg_src  = 1'b0;
    carry_we = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    reg_addr = ir_q[REG_ADDR_W-1:0];

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (!opc_hi_ok) begin
          illegal = 1'b1;
        end else begin
          case (opc_lo)
            OP_NOP:                                 state_d = S_FETCH;
            OP_ADD, OP_SUB, OP_LDM, OP_LD, OP_INC:  state_d = S_EXEC;
            OP_XCH:                                 state_d = S_XCH1;
            OP_JCN, OP_JUN:                         state_d = S_FETCH2;
            OP_HLT:                                 state_d = S_HALT;
            default:                                illegal = 1'b1;
          endcase
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opc_lo)
          OP_ADD: begin alu_op = 2'b01; acc_we = 1'b1; carry_we = 1'b1; end
          OP_SUB: begin alu_op = 2'b10; acc_we = 1'b1; carry_we = 1'b1; end
          OP_LDM: begin acc_src = 2'd2; acc_we = 1'b1; end
          OP_LD:  begin acc_src = 2'd1; acc_we = 1'b1; end
          OP_INC: begin alu_op = 2'b11; reg_we = 1'b1; end
          default: ;
        endcase
      end
      // Swap goes acc -> tmp, R[r] -> acc, tmp -> R[r], one write port per cycle.
      S_XCH1: begin tmp_we = 1'b1; state_d = S_XCH2; end
      S_XCH2: begin acc_src = 2'd1; acc_we = 1'b1; state_d = S_XCH3; end
      S_XCH3: begin reg_src = 1'b1; reg_we = 1'b1; state_d = S_FETCH; end
      S_FETCH2: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          op2_load = 1'b1;
          pc_inc   = 1'b1;
          state_d  = S_JUMP;
        end
      end
      S_JUMP: begin
        pc_load = (opc_lo == OP_JUN) || ((opc_lo == OP_JCN) && (bus.carry_in == ir_q[0]));
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted   = 1'b1;
        reg_addr = '0;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= bus.instr_in;
    end
  end

  // Reset gates outputs directly so an in-flight request drops in the same cycle.
  assign bus.mem_req  = mem_req  & ~reset;
  assign bus.ir_load  = ir_load  & ~reset;
  assign bus.op2_load = op2_load & ~reset;
  assign bus.pc_inc   = pc_inc   & ~reset;
  assign bus.pc_load  = pc_load  & ~reset;
  assign bus.alu_op   = reset ? 2'b00 : alu_op;
  assign bus.acc_we   = acc_we   & ~reset;
  assign bus.acc_src  = reset ? 2'b00 : acc_src;
  assign bus.tmp_we   = tmp_we   & ~reset;
  assign bus.reg_we   = reg_we   & ~reset;
  assign bus.reg_src  = reg_src  & ~reset;
  assign bus.reg_addr = reset ? '0 : reg_addr;
  assign bus.carry_we = carry_we & ~reset;
  assign bus.halted   = halted   & ~reset;
  assign bus.illegal  = illegal  & ~reset;

endmodule
